// File: rtl/line_pattern_gen_pkg.sv
// Shared video definitions: pattern mode encodings, RGB888 pixel type and the
// fixed colour-bar palette used by the line pattern generator.
package video_pkg;

  typedef logic [23:0] rgb888_t;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_BARS    = 2'd2,
    PAT_RAMP    = 2'd3
  } pat_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  localparam int NUM_BARS = 8;

  // Classic SMPTE-style order, white down to black.
  localparam rgb888_t BAR_COLORS [NUM_BARS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/line_pattern_gen_if.sv
// Request side and line-buffer write port between VideoSystem and the
// pattern generator; master is the generator, slave is the video system.
interface line_pattern_gen_if #(
  parameter int ADDR_W = 10,
  parameter int Y_W    = 10,
  parameter int DATA_W = 24
);

  logic              line_request;
  logic [Y_W-1:0]    y_pos;
  logic [1:0]        mode;
  logic [DATA_W-1:0] color_a;
  logic [DATA_W-1:0] color_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic              line_done;
  logic              overrun;

  modport master (
    input  line_request, y_pos, mode, color_a, color_b,
    output wr_addr, wr_data, wr_en, busy, line_done, overrun
  );

  modport slave (
    output line_request, y_pos, mode, color_a, color_b,
    input  wr_addr, wr_data, wr_en, busy, line_done, overrun
  );

endinterface

// File: rtl/line_pattern_gen_pattern_pixel.sv
// Combinational pixel function: maps the current x, bar index and the
// line-latched y/mode/colours to one pixel value.
module pattern_pixel
  import video_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int Y_W       = 10,
  parameter int DATA_W    = 24,
  parameter int TILE_LOG2 = 4
) (
  input  logic [ADDR_W-1:0] x_i,
  input  logic [2:0]        bar_i,
  input  logic [Y_W-1:0]    y_i,
  input  pat_mode_e         mode_i,
  input  logic [DATA_W-1:0] color_a_i,
  input  logic [DATA_W-1:0] color_b_i,
  output logic [DATA_W-1:0] pixel_o
);

  logic [7:0] grey;
  logic       unused_bits;

  // Only a few bits of x and y feed the patterns; fold the rest away.
  assign unused_bits = ^{x_i, y_i};

  always_comb begin
    grey    = x_i[ADDR_W-1 -: 8];
    pixel_o = color_a_i;
    unique case (mode_i)
      PAT_SOLID:   pixel_o = color_a_i;
      PAT_CHECKER: pixel_o = (x_i[TILE_LOG2] ^ y_i[TILE_LOG2]) ? color_b_i : color_a_i;
      PAT_BARS:    pixel_o = DATA_W'(BAR_COLORS[bar_i]);
      PAT_RAMP:    pixel_o = DATA_W'({grey, grey, grey});
      default:     pixel_o = color_a_i;
    endcase
  end

endmodule

// File: rtl/line_pattern_gen.sv
// Per-line test-pattern generator: on each rising edge of line_request it
// writes H_RES pixels, one per clock, into the VideoSystem line buffer.
module line_pattern_gen
  import video_pkg::*;
#(
  parameter int H_RES     = 800,
  parameter int ADDR_W    = 10,
  parameter int Y_W       = 10,
  parameter int DATA_W    = 24,
  parameter int TILE_LOG2 = 4
) (
  input logic              clk_psram,
  input logic              rst_n,
  line_pattern_gen_if.master bus
);

  localparam int BW = H_RES / NUM_BARS;
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(H_RES - 1);
  localparam logic [ADDR_W-1:0] BAR_LAST = ADDR_W'(BW - 1);

  gen_state_e        state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2:0]        bar_q, bar_d;
  pat_mode_e         mode_q, mode_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DATA_W-1:0] ca_q, ca_d;
  logic [DATA_W-1:0] cb_q, cb_d;
  logic              req_d_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              req_edge;
  logic [DATA_W-1:0] pixel;

  assign req_edge = bus.line_request & ~req_d_q;

  pattern_pixel #(
    .ADDR_W    (ADDR_W),
    .Y_W       (Y_W),
    .DATA_W    (DATA_W),
    .TILE_LOG2 (TILE_LOG2)
  ) u_pixel (
    .x_i       (x_q),
    .bar_i     (bar_q),
    .y_i       (y_q),
    .mode_i    (mode_q),
    .color_a_i (ca_q),
    .color_b_i (cb_q),
    .pixel_o   (pixel)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    bar_d     = bar_q;
    mode_d    = mode_q;
    y_d       = y_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ovr_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          mode_d  = pat_mode_e'(bus.mode);
          y_d     = bus.y_pos;
          ca_d    = bus.color_a;
          cb_d    = bus.color_b;
          x_d     = '0;
          cnt_d   = '0;
          bar_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = x_q;
        wr_data_d = pixel;
        ovr_d     = req_edge;
        if (x_q == X_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          x_d = x_q + 1'b1;
          // Bar 7 never advances, so any H_RES remainder widens the last bar.
          if (bar_q != 3'd7 && cnt_q == BAR_LAST) begin
            bar_d = bar_q + 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      cnt_q     <= '0;
      bar_q     <= '0;
      mode_q    <= PAT_SOLID;
      y_q       <= '0;
      ca_q      <= '0;
      cb_q      <= '0;
      req_d_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      bar_q     <= bar_d;
      mode_q    <= mode_d;
      y_q       <= y_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      req_d_q   <= bus.line_request;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.line_done = done_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_line_pattern_gen.sv
// Bench for line_pattern_gen: queue-based line model checked every cycle plus
// hand-computed pixel/handshake expectations; a second 804-pixel instance covers bar 7 widening.
module tb_line_pattern_gen;

  logic clk;
  logic rst_n;

  line_pattern_gen_if #(.ADDR_W(10), .Y_W(10), .DATA_W(24)) if0 ();
  line_pattern_gen_if #(.ADDR_W(10), .Y_W(10), .DATA_W(24)) if1 ();

  line_pattern_gen #(.H_RES(800)) dut (.clk_psram(clk), .rst_n(rst_n), .bus(if0));
  line_pattern_gen #(.H_RES(804)) dut2 (.clk_psram(clk), .rst_n(rst_n), .bus(if1));

  assign if1.line_request = if0.line_request;
  assign if1.y_pos        = if0.y_pos;
  assign if1.mode         = if0.mode;
  assign if1.color_a      = if0.color_a;
  assign if1.color_b      = if0.color_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [23:0] data;
    bit          done;
  } wr_t;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int errors = 0;
  int checks = 0;

  wr_t         q[$];
  bit          m_prev = 0;
  bit          e_en = 0, e_busy = 0, e_done = 0, e_ovr = 0;
  int          e_addr = 0;
  logic [23:0] e_data = '0;

  logic [23:0] cap  [1024];
  logic [23:0] cap2 [1024];
  int cyc = 0, wtot = 0, wtot2 = 0, btot = 0, otot = 0;
  int done_addr = -1, first_after_rst = -1, last_gap = -1, prev_wr_cyc = 0;
  bit rst_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(int x, int y, int md, logic [23:0] a,
                                             logic [23:0] b, int hres);
    int idx;
    int g;
    case (md)
      0: return a;
      1: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? b : a;
      2: begin
        idx = x / (hres / 8);
        if (idx > 7) idx = 7;
        return bar_tab[idx];
      end
      default: begin
        g = (x >> 2) & 255;
        return {g[7:0], g[7:0], g[7:0]};
      end
    endcase
  endfunction

  // A line is a queue of 800 expected writes, popped one per clock.
  task automatic model_loop();
    bit  edge_seen;
    wr_t w;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_prev = 0;
        e_en = 0; e_busy = 0; e_done = 0; e_ovr = 0; e_addr = 0; e_data = '0;
      end else begin
        edge_seen = if0.line_request && !m_prev;
        m_prev = if0.line_request;
        e_en = 0; e_busy = 0; e_done = 0; e_ovr = 0;
        if (q.size() > 0) begin
          w = q.pop_front();
          e_en = 1; e_busy = 1; e_addr = w.addr; e_data = w.data; e_done = w.done;
          e_ovr = edge_seen;
        end else if (edge_seen) begin
          for (int i = 0; i < 800; i++) begin
            w.addr = i;
            w.data = model_pix(i, int'(if0.y_pos), int'(if0.mode), if0.color_a, if0.color_b, 800);
            w.done = (i == 799);
            q.push_back(w);
          end
        end
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rst_seen = 1;
        chk("rst_wr_en", {31'b0, if0.wr_en}, 0);
        chk("rst_busy", {31'b0, if0.busy}, 0);
        chk("rst_done", {31'b0, if0.line_done}, 0);
        chk("rst_overrun", {31'b0, if0.overrun}, 0);
        chk("rst_addr", {22'b0, if0.wr_addr}, 0);
        chk("rst_data", {8'b0, if0.wr_data}, 0);
      end else begin
        chk("wr_en", {31'b0, if0.wr_en}, {31'b0, e_en});
        chk("busy", {31'b0, if0.busy}, {31'b0, e_busy});
        chk("line_done", {31'b0, if0.line_done}, {31'b0, e_done});
        chk("overrun", {31'b0, if0.overrun}, {31'b0, e_ovr});
        if (e_en) begin
          chk("wr_addr", {22'b0, if0.wr_addr}, e_addr);
          chk("wr_data", {8'b0, if0.wr_data}, {8'b0, e_data});
        end
      end
      if (if0.wr_en) begin
        cap[if0.wr_addr] = if0.wr_data;
        wtot++;
        if (rst_seen) begin
          first_after_rst = int'(if0.wr_addr);
          rst_seen = 0;
        end
        if (if0.wr_addr == 0 && prev_wr_cyc > 0) last_gap = cyc - prev_wr_cyc;
        prev_wr_cyc = cyc;
      end
      if (if0.busy) btot++;
      if (if0.overrun) otot++;
      if (if0.line_done) done_addr = int'(if0.wr_addr);
      if (if1.wr_en) begin
        cap2[if1.wr_addr] = if1.wr_data;
        wtot2++;
      end
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!if0.line_done && n < 3000) begin
      nstep();
      n++;
    end
    chk(nm, {31'b0, if0.line_done}, 1);
  endtask

  task automatic wait_writes(input int base, input int n, input string nm);
    int k = 0;
    while ((wtot - base) < n && k < 3000) begin
      nstep();
      k++;
    end
    chk(nm, {31'b0, ((wtot - base) >= n)}, 1);
  endtask

  task automatic run_line(input logic [1:0] md, input logic [9:0] y,
                          input logic [23:0] a, input logic [23:0] b,
                          output int writes, output int busys);
    int wb, bb;
    nstep();
    if0.mode = md; if0.y_pos = y; if0.color_a = a; if0.color_b = b;
    if0.line_request = 1'b1;
    wb = wtot; bb = btot;
    wait_done("line_done_seen");
    nstep();
    if0.line_request = 1'b0;
    repeat (8) nstep();
    writes = wtot - wb;
    busys  = btot - bb;
  endtask

  initial begin
    int wr, bs, wb, wb2, ob;
    rst_n = 1'b1;
    if0.line_request = 1'b0; if0.y_pos = '0; if0.mode = 2'd0;
    if0.color_a = '0; if0.color_b = '0;
    fork
      model_loop();
      compare_loop();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) nstep();
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) nstep();

    // Solid colour: full line, contiguous addresses, done on the last write.
    run_line(2'd0, 10'd0, 24'h123456, 24'h0, wr, bs);
    chk("solid_writes", wr, 800);
    chk("solid_busy_cycles", bs, 800);
    chk("solid_done_addr", done_addr, 799);
    chk("solid_px0", {8'b0, cap[0]}, 32'h123456);
    chk("solid_px799", {8'b0, cap[799]}, 32'h123456);

    // Checkerboard, both y polarities.
    run_line(2'd1, 10'd16, 24'h444444, 24'hEEEEEE, wr, bs);
    chk("chk_y16_px0", {8'b0, cap[0]}, 32'hEEEEEE);
    chk("chk_y16_px15", {8'b0, cap[15]}, 32'hEEEEEE);
    chk("chk_y16_px16", {8'b0, cap[16]}, 32'h444444);
    chk("chk_y16_px31", {8'b0, cap[31]}, 32'h444444);
    run_line(2'd1, 10'd0, 24'h444444, 24'hEEEEEE, wr, bs);
    chk("chk_y0_px0", {8'b0, cap[0]}, 32'h444444);
    chk("chk_y0_px16", {8'b0, cap[16]}, 32'hEEEEEE);

    // Colour bars at 800 and 804 pixels.
    wb2 = wtot2;
    run_line(2'd2, 10'd0, 24'h0, 24'h0, wr, bs);
    chk("bars_px0", {8'b0, cap[0]}, 32'hFFFFFF);
    chk("bars_px99", {8'b0, cap[99]}, 32'hFFFFFF);
    chk("bars_px100", {8'b0, cap[100]}, 32'hFFFF00);
    chk("bars_px699", {8'b0, cap[699]}, 32'h0000FF);
    chk("bars_px700", {8'b0, cap[700]}, 32'h000000);
    chk("bars_px799", {8'b0, cap[799]}, 32'h000000);
    chk("bars804_writes", wtot2 - wb2, 804);
    chk("bars804_px699", {8'b0, cap2[699]}, 32'h0000FF);
    chk("bars804_px700", {8'b0, cap2[700]}, 32'h000000);
    chk("bars804_px803", {8'b0, cap2[803]}, 32'h000000);

    // Grey ramp.
    run_line(2'd3, 10'd0, 24'h0, 24'h0, wr, bs);
    chk("ramp_px0", {8'b0, cap[0]}, 32'h000000);
    chk("ramp_px4", {8'b0, cap[4]}, 32'h010101);
    chk("ramp_px799", {8'b0, cap[799]}, 32'hC7C7C7);

    // Overrun mid-line, mid-line input change, then back-to-back line.
    nstep();
    if0.mode = 2'd0; if0.color_a = 24'hABCDEF; if0.line_request = 1'b1;
    wb = wtot; ob = otot;
    wait_writes(wb, 200, "wait_200");
    if0.mode = 2'd3; if0.color_a = 24'h0;
    wait_writes(wb, 300, "wait_300");
    if0.line_request = 1'b0;
    nstep();
    if0.line_request = 1'b1;
    wait_writes(wb, 700, "wait_700");
    if0.line_request = 1'b0;
    wait_done("ovr_line_done");
    if0.line_request = 1'b1;
    nstep();
    chk("ovr_writes", wtot - wb, 800);
    chk("ovr_pulses", otot - ob, 1);
    chk("ovr_px500", {8'b0, cap[500]}, 32'hABCDEF);
    chk("ovr_px799", {8'b0, cap[799]}, 32'hABCDEF);
    wb = wtot;
    nstep();
    chk("b2b_gap", last_gap, 2);
    wait_done("b2b_line_done");
    chk("b2b_writes", wtot - wb, 800);
    chk("b2b_px799", {8'b0, cap[799]}, 32'hC7C7C7);
    nstep();
    if0.line_request = 1'b0;
    repeat (8) nstep();

    // Reset mid-line with the request held high through release.
    if0.mode = 2'd0; if0.color_a = 24'h777777; if0.line_request = 1'b1;
    wb = wtot;
    wait_writes(wb, 400, "wait_400");
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", {31'b0, if0.wr_en}, 0);
    chk("midrst_busy", {31'b0, if0.busy}, 0);
    chk("midrst_addr", {22'b0, if0.wr_addr}, 0);
    repeat (3) nstep();
    @(negedge clk); #2 rst_n = 1'b1;
    wb = wtot;
    wait_done("post_rst_done");
    chk("post_rst_writes", wtot - wb, 800);
    chk("post_rst_first_addr", first_after_rst, 0);
    chk("post_rst_px0", {8'b0, cap[0]}, 32'h777777);
    nstep();
    if0.line_request = 1'b0;
    repeat (8) nstep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
